c3lib_dly_cal_ctrl: RTL



---
 rtl/c3lib_dly_cal_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/c3lib_dly_cal_ctrl.sv
// Delay-line calibration controller: sweeps the delay code upward, majority-votes the
// phase detector at each code and locks the first code where the detector goes 0 -> 1.
module c3lib_dly_cal_ctrl #(
  parameter int unsigned CODE_W     = 6,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned VOTE_CNT   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cal_en,
  input  logic              cal_start,
  input  logic              ph_det,
  input  logic              ovr_en,
  input  logic [CODE_W-1:0] ovr_code,
  output logic [CODE_W-1:0] dly_code,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_err,
  output logic [CODE_W-1:0] lock_code
);

  localparam int unsigned CNT_MAX = (SETTLE_CYC > VOTE_CNT) ? SETTLE_CYC : VOTE_CNT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  VOTE_LAST   = CNT_W'(VOTE_CNT - 1);
  localparam logic [CNT_W-1:0]  VOTE_HALF   = CNT_W'(VOTE_CNT / 2);
  localparam logic [CODE_W-1:0] CODE_MAX    = {CODE_W{1'b1}};

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StSample,
    StEval,
    StDone,
    StErr
  } state_e;

  state_e             r_state, w_state;
  logic [CODE_W-1:0]  r_code, w_code;
  logic [CODE_W-1:0]  r_lock, w_lock;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [CNT_W-1:0]   r_ones, w_ones;
  logic               r_seen_low, w_seen_low;
  logic               r_busy, r_done, r_err;
  logic               w_vote;

  assign w_vote = (r_ones > VOTE_HALF);

  always_comb begin
    w_state    = r_state;
    w_code     = r_code;
    w_lock     = r_lock;
    w_cnt      = r_cnt;
    w_ones     = r_ones;
    w_seen_low = r_seen_low;
    if (!cal_en) begin
      // lock_code survives a disable; everything else returns to idle.
      w_state = StIdle;
      w_code  = '0;
      w_cnt   = '0;
    end else begin
      case (r_state)
        StIdle, StDone, StErr: begin
          if (cal_start) begin
            w_state    = StSettle;
            w_code     = '0;
            w_seen_low = 1'b0;
            w_cnt      = '0;
          end
        end
        StSettle: begin
          if (r_cnt == SETTLE_LAST) begin
            w_state = StSample;
            w_cnt   = '0;
            w_ones  = '0;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        StSample: begin
          w_ones = r_ones + CNT_W'(ph_det);
          if (r_cnt == VOTE_LAST) begin
            w_state = StEval;
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        StEval: begin
          if (w_vote && r_seen_low) begin
            w_lock  = r_code;
            w_state = StDone;
          end else begin
            if (!w_vote) w_seen_low = 1'b1;
            if (r_code == CODE_MAX) begin
              w_state = StErr;
            end else begin
              w_code  = r_code + CODE_W'(1);
              w_state = StSettle;
            end
          end
        end
        default: w_state = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_code     <= '0;
      r_lock     <= '0;
      r_cnt      <= '0;
      r_ones     <= '0;
      r_seen_low <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_code     <= w_code;
      r_lock     <= w_lock;
      r_cnt      <= w_cnt;
      r_ones     <= w_ones;
      r_seen_low <= w_seen_low;
      r_busy     <= (w_state == StSettle) || (w_state == StSample) || (w_state == StEval);
      r_done     <= (w_state == StDone);
      r_err      <= (w_state == StErr);
    end
  end

  assign dly_code  = ovr_en ? ovr_code : r_code;
  assign cal_busy  = r_busy;
  assign cal_done  = r_done;
  assign cal_err   = r_err;
  assign lock_code = r_lock;

endmodule
